// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-word pipeline with per-stage hold/kill and bubble insertion at stall boundaries.
// Define CTRL_PIPE_DS_EN to add branch delay-slot tracking (ds_pending, per-stage ds, out_ds).

module ctrl_pipe_stage #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          hold,
    input  logic          bubble,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    // Kill beats hold; a bubble is loaded only when this stage actually advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       q <= '0;
        else if (flush) q <= '0;
        else if (!hold) q <= bubble ? '0 : d;
    end
endmodule

module ctrl_pipe #(
    parameter int W      = 19,
    parameter int STAGES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [W-1:0]          in_ctrl,
    input  logic                  in_branch,
    input  logic                  if_stall,
    input  logic [STAGES-1:0]     stall,
    input  logic [STAGES-1:0]     flush,
    output logic [STAGES*W-1:0]   out_ctrl,
    output logic [STAGES-1:0]     out_valid,
    output logic [STAGES-1:0]     out_ds,
    output logic                  busy
);
    typedef struct packed {
`ifdef CTRL_PIPE_DS_EN
        logic         ds;
`endif
        logic         valid;
        logic [W-1:0] ctrl;
    } stage_t;

    localparam int DW = $bits(stage_t);

    stage_t [STAGES-1:0] st;
    stage_t              head;
    logic   [STAGES-1:0] hold;

`ifdef CTRL_PIPE_DS_EN
    logic ds_pending;

    // Remembers that the previous decoded instruction was a branch; flush does not touch it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           ds_pending <= 1'b0;
        else if (!if_stall) ds_pending <= in_branch & in_valid;
    end

    assign head = '{ds: ds_pending, valid: in_valid, ctrl: in_ctrl};
`else
    logic unused_ds_inputs;
    assign unused_ds_inputs = in_branch | if_stall;
    assign head = '{valid: in_valid, ctrl: in_ctrl};
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Any stall at or below this stage freezes it.
        assign hold[k] = |stall[STAGES-1:k];

        if (k == 0) begin : g_head
            ctrl_pipe_stage #(.DW(DW)) u_stage (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush[k]),
                .hold   (hold[k]),
                .bubble (1'b0),
                .d      (head),
                .q      (st[k])
            );
        end else begin : g_body
            ctrl_pipe_stage #(.DW(DW)) u_stage (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush[k]),
                .hold   (hold[k]),
                .bubble (hold[k-1]),
                .d      (st[k-1]),
                .q      (st[k])
            );
        end

        assign out_ctrl[k*W +: W] = st[k].ctrl;
        assign out_valid[k]       = st[k].valid;
`ifdef CTRL_PIPE_DS_EN
        assign out_ds[k]          = st[k].ds;
`else
        assign out_ds[k]          = 1'b0;
`endif
    end

    assign busy = |out_valid;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: scoreboard bench for ctrl_pipe (W=19, STAGES=3); delay-slot expectations
// follow CTRL_PIPE_DS_EN.
module tb_ctrl_pipe;
    localparam int W = 19;
    localparam int S = 3;
`ifdef CTRL_PIPE_DS_EN
    localparam bit DS_ON = 1'b1;
`else
    localparam bit DS_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_ctrl = '0;
    logic           in_branch = 1'b0;
    logic           if_stall = 1'b0;
    logic [S-1:0]   stall = '0;
    logic [S-1:0]   flush = '0;
    logic [S*W-1:0] out_ctrl;
    logic [S-1:0]   out_valid;
    logic [S-1:0]   out_ds;
    logic           busy;

    ctrl_pipe #(.W(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ctrl   (in_ctrl),
        .in_branch (in_branch),
        .if_stall  (if_stall),
        .stall     (stall),
        .flush     (flush),
        .out_ctrl  (out_ctrl),
        .out_valid (out_valid),
        .out_ds    (out_ds),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] ctrl;
        logic         ds;
    } sb_t;

    sb_t sb[$];
    int  n_chk = 0;
    int  n_bad = 0;
    bit  ds_p  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] sc(input int k);
        return out_ctrl[k*W +: W];
    endfunction

    // Drive one cycle; push words the head stage accepts, pop when stage 2 loads a real word.
    task automatic step(input bit iv, input logic [W-1:0] c, input bit br, input bit ifs,
                        input logic [S-1:0] st, input logic [S-1:0] fl);
        sb_t e;
        sb_t g;
        in_valid = iv; in_ctrl = c; in_branch = br; if_stall = ifs; stall = st; flush = fl;
        if (iv && !fl[0] && st == '0) begin
            e.ctrl = c;
            e.ds   = DS_ON & ds_p;
            sb.push_back(e);
        end
        if (!ifs) ds_p = br & iv;
        @(posedge clk);
        #1;
        if (!st[S-1] && !fl[S-1] && out_valid[S-1]) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                g = sb.pop_front();
                chk("sb_ctrl", 32'(sc(S-1)), 32'(g.ctrl));
                chk("sb_ds", 32'(out_ds[S-1]), 32'(g.ds));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rc;
        logic [S-1:0] rs;
        bit           rv, rb, rf;

        #1 rst = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ctrl", 32'(out_ctrl), 32'd0);
        chk("rst_ds", 32'(out_ds), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #10 rst = 1'b1;

        // Fill: word 1 reaches stage 2 on the third edge.
        step(1'b1, 19'h1, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b1, 19'h2, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("fill_s0", 32'(sc(0)), 32'h2);
        step(1'b1, 19'h3, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("fill_vld", 32'(out_valid), 32'b111);
        chk("fill_s2_e3", 32'(sc(2)), 32'h1);
        chk("fill_busy", 32'(busy), 32'd1);
        step(1'b1, 19'h4, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("fill_s2_e4", 32'(sc(2)), 32'h2);

        // Stall at stage 1: stages 0,1 frozen, stage 2 takes a bubble each cycle.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 19'h7ffff, 1'b0, 1'b0, 3'b010, 3'b000);
            chk("stl_vld", 32'(out_valid), 32'b011);
            chk("stl_s2", 32'(sc(2)), 32'h0);
            chk("stl_s1", 32'(sc(1)), 32'h3);
            chk("stl_s0", 32'(sc(0)), 32'h4);
        end
        step(1'b1, 19'h5, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("stl_resume", 32'(sc(2)), 32'h3);

        // Flush wins over hold at stage 0; stage 1 bubbles, stage 2 advances.
        step(1'b1, 19'h6, 1'b0, 1'b0, 3'b001, 3'b001);
        void'(sb.pop_back());
        chk("fl_vld", 32'(out_valid), 32'b100);
        chk("fl_s0", 32'(sc(0)), 32'h0);
        chk("fl_s2", 32'(sc(2)), 32'h4);

        // Delay slot: branch 7, then 8 enters flagged; fetch stall keeps the flag for 9.
        step(1'b1, 19'h7, 1'b1, 1'b0, 3'b000, 3'b000);
        step(1'b1, 19'h8, 1'b0, 1'b1, 3'b000, 3'b000);
        chk("ds_e1", 32'(out_ds), 32'(DS_ON ? 3'b001 : 3'b000));
        step(1'b1, 19'h9, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("ds_e2", 32'(out_ds), 32'(DS_ON ? 3'b011 : 3'b000));
        step(1'b1, 19'ha, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("ds_e3", 32'(out_ds), 32'(DS_ON ? 3'b110 : 3'b000));

        // Killed branch still arms the delay slot for the next word.
        step(1'b1, 19'hb, 1'b1, 1'b0, 3'b000, 3'b001);
        chk("dsfl_s0", 32'(out_valid[0]), 32'd0);
        step(1'b1, 19'hc, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("dsfl_ds0", 32'(out_ds[0]), 32'(DS_ON));

        for (int i = 0; i < 60; i++) begin
            rv = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            rf = ($urandom_range(0, 3) == 0);
            rc = 19'($urandom);
            rs = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            step(rv, rc, rb, rf, rs, 3'b000);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 19'h0, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Async reset in the middle of a stall.
        step(1'b1, 19'h21, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b1, 19'h22, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b1, 19'h23, 1'b1, 1'b0, 3'b000, 3'b000);
        step(1'b1, 19'h24, 1'b0, 1'b0, 3'b100, 3'b000);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #3 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ctrl", 32'(out_ctrl), 32'd0);
        chk("arst_ds", 32'(out_ds), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        sb.delete();
        ds_p = 1'b0;
        #1 rst = 1'b1;
        step(1'b1, 19'h55, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("post_rst_vld", 32'(out_valid), 32'b001);
        chk("post_rst_s0", 32'(sc(0)), 32'h55);
        chk("post_rst_ds", 32'(out_ds), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 19'h0, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("sb_final", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter W, 19, control-word width per stage (W >= 1).
REQ-002 SHALL have parameter STAGES, 3, number of pipeline register stages after decode (STAGES >= 1); stage 0 = ID/EX, stage STAGES-1 = last.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  decode-stage word is a real instruction.
REQ-006 SHALL have port in_ctrl  in  W  decoded control word entering stage 0.
REQ-007 SHALL have port in_branch  in  1  decode-stage instruction is a branch or jump.
REQ-008 SHALL have port if_stall  in  1  fetch/decode hold; freezes the delay-slot tracker.
REQ-009 SHALL have port stall  in  STAGES  per-stage hold request, bit k = stage k.
REQ-010 SHALL have port flush  in  STAGES  per-stage kill, bit k = stage k.
REQ-011 SHALL have port out_ctrl  out  STAGES*W  stage k word at bits [k*W +: W].
REQ-012 SHALL have port out_valid  out  STAGES  per-stage valid.
REQ-013 SHALL have port out_ds  out  STAGES  per-stage delay-slot flag.
REQ-014 SHALL have port busy  out  1  OR of out_valid.

Function
REQ-015 Effective hold SHALL be h[k] = OR of stall[STAGES-1:k]; a downstream stall always holds every upstream stage.
REQ-016 Per-stage priority each edge SHALL be: flush[k] > h[k] > advance.
REQ-017 Flush SHALL load valid=0, ctrl=0, ds=0 into stage k, even when h[k]=1.
REQ-018 Hold SHALL keep stage k valid, ctrl and ds unchanged.
REQ-019 Advance of stage 0 SHALL load {in_valid, in_ctrl, ds_pending}; advance of stage k>0 SHALL load stage k-1 contents.
REQ-020 When stage k advances while h[k-1]=1 (stall boundary), stage k SHALL load a bubble (valid=0, ctrl=0, ds=0); one bubble per stalled cycle.
REQ-021 Control words SHALL move one stage per unheld cycle; latency from in_ctrl to stage k output SHALL be k+1 cycles with no stalls.
REQ-022 The internal ds_pending register SHALL, when if_stall=0, load in_branch & in_valid, and SHALL hold when if_stall=1.
REQ-023 ds_pending SHALL NOT be cleared by flush; flush kills only stage registers.
REQ-024 busy SHALL be combinational OR of out_valid with no added latency.
REQ-025 Outputs SHALL come directly from stage registers; no combinational path from stall/flush to out_*.

Reset
REQ-026 rst=0 SHALL asynchronously clear all out_valid, out_ctrl, out_ds and ds_pending to 0; busy SHALL be 0.
REQ-027 Reset asserted mid-stall or mid-flush SHALL override both; the first edge after release SHALL apply normal REQ-016 rules.

Configuration
REQ-028 Macro CTRL_PIPE_DS_EN SHALL compile in delay-slot tracking (ds_pending, per-stage ds bits, REQ-019/022/023 ds behaviour).
REQ-029 Without CTRL_PIPE_DS_EN, out_ds SHALL be constant 0, in_branch and if_stall SHALL be ignored, and no ds state SHALL exist.

Verification (W=19, STAGES=3, CTRL_PIPE_DS_EN defined unless noted)
REQ-030 Reset release, in_valid=1, in_ctrl=19'h00001,02,03 on three edges, no stall -> stage 2 shows 19'h00001 on edge 3, 19'h00002 edge 4, out_valid=3'b111 at edge 3.
REQ-031 Pipe full, stall=3'b010 for 2 cycles -> stages 0,1 hold, stage 2 loads bubble twice (out_valid[2]=0, ctrl 0), then resumes with held stage-1 word.
REQ-032 stall=3'b001 and flush=3'b001 same edge -> stage 0 valid=0, ctrl=0; stages 1,2 advance normally.
REQ-033 in_branch=1, in_valid=1 at edge n, if_stall=0 -> word entering stage 0 at edge n+1 has out_ds[0]=1, reaching out_ds[2]=1 at edge n+3; with if_stall=1 at edge n+1, ds_pending stays 1 until released.
REQ-034 Without CTRL_PIPE_DS_EN, repeat REQ-033 -> out_ds=3'b000 throughout.
REQ-035 rst=0 asserted between edges with pipe full and stall=3'b100 -> all outputs 0 immediately, busy=0, before next clk edge.
